// File: rtl/apbarb.sv
// Round-robin arbiter sharing one APB completer between N valid/ready requesters.
// Define APBARB_TIMEOUT_EN to abort ACCESS phases that exceed TOUT cycles.
module apbarb #(
    parameter int N    = 4,
    parameter int RW   = 32,
    parameter int RAW  = 5,
    parameter int TOUT = 16
) (
    input  logic             apb_pclk,
    input  logic             nreset,
    input  logic [N-1:0]     req_valid,
    input  logic [N-1:0]     req_write,
    input  logic [N*RAW-1:0] req_addr,
    input  logic [N*RW-1:0]  req_wdata,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     rsp_valid,
    output logic [RW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             apb_psel,
    output logic             apb_penable,
    output logic             apb_pwrite,
    output logic [RAW-1:0]   apb_paddr,
    output logic [RW-1:0]    apb_pwdata,
    output logic [3:0]       apb_pstrb,
    output logic [2:0]       apb_pprot,
    input  logic             apb_pready,
    input  logic [RW-1:0]    apb_prdata,
    input  logic             apb_pslverr
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (N < 2 || N > 16 || TOUT < 1) begin : g_param_chk
        $error("apbarb: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    win_q, win_d;
    logic [IW-1:0]    pick, idx;
    logic             hit;
    logic             psel_d, pen_d, pwrite_d, err_d;
    logic [RAW-1:0]   paddr_d;
    logic [RW-1:0]    pwdata_d, rdata_d;
    logic [N-1:0]     rdy_d, rsv_d;
    logic [RAW-1:0]   addr_a  [N];
    logic [RW-1:0]    wdata_a [N];

`ifdef APBARB_TIMEOUT_EN
    localparam int CW = $clog2(TOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign addr_a[g]  = req_addr[g*RAW +: RAW];
        assign wdata_a[g] = req_wdata[g*RW +: RW];
    end

    assign apb_pstrb = 4'hF;
    assign apb_pprot = 3'b000;

    // Scan from farthest to nearest so the requester just after last wins.
    always_comb begin
        pick = last_q;
        hit  = 1'b0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % N);
            if (req_valid[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        psel_d   = apb_psel;
        pen_d    = apb_penable;
        pwrite_d = apb_pwrite;
        paddr_d  = apb_paddr;
        pwdata_d = apb_pwdata;
        rdy_d    = '0;
        rsv_d    = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
`ifdef APBARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d  = SETUP;
                    last_d   = pick;
                    win_d    = pick;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    pwrite_d = req_write[pick];
                    paddr_d  = addr_a[pick];
                    pwdata_d = wdata_a[pick];
                    rdy_d    = N'(1) << pick;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                pen_d   = 1'b1;
`ifdef APBARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (apb_pready) begin
                    state_d = IDLE;
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    rsv_d   = N'(1) << win_q;
                    rdata_d = apb_pwrite ? '0 : apb_prdata;
                    err_d   = apb_pslverr;
                end
`ifdef APBARB_TIMEOUT_EN
                else if (cnt_q == CW'(TOUT - 1)) begin
                    state_d = IDLE;
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    rsv_d   = N'(1) << win_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            last_q      <= IW'(N - 1);
            win_q       <= '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
`ifdef APBARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            apb_psel    <= psel_d;
            apb_penable <= pen_d;
            apb_pwrite  <= pwrite_d;
            apb_paddr   <= paddr_d;
            apb_pwdata  <= pwdata_d;
            req_ready   <= rdy_d;
            rsp_valid   <= rsv_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= err_d;
`ifdef APBARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apbarb.sv
// Randomized and directed bench for apbarb against a transaction-level model.
// Honours APBARB_TIMEOUT_EN the same way the design does.
module tb_apbarb;

    localparam int N    = 4;
    localparam int RW   = 32;
    localparam int RAW  = 5;
    localparam int TOUT = 8;

    logic             apb_pclk = 1'b0;
    logic             nreset   = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_write = '0;
    logic [N*RAW-1:0] req_addr  = '0;
    logic [N*RW-1:0]  req_wdata = '0;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [RW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             apb_psel, apb_penable, apb_pwrite;
    logic [RAW-1:0]   apb_paddr;
    logic [RW-1:0]    apb_pwdata;
    logic [3:0]       apb_pstrb;
    logic [2:0]       apb_pprot;
    logic             apb_pready  = 1'b1;
    logic [RW-1:0]    apb_prdata  = '0;
    logic             apb_pslverr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    apbarb #(.N(N), .RW(RW), .RAW(RAW), .TOUT(TOUT)) dut (
        .apb_pclk(apb_pclk), .nreset(nreset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_paddr(apb_paddr),
        .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pprot(apb_pprot), .apb_pready(apb_pready),
        .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr)
    );

    always #5 apb_pclk = ~apb_pclk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    endtask

    // Model: a transfer is a grant, one SETUP cycle, then ACCESS cycles until done.
    logic           e_psel = 0, e_pen = 0, e_pwrite = 0, e_err = 0;
    logic [RAW-1:0] e_paddr = '0;
    logic [RW-1:0]  e_pwdata = '0, e_rdata = '0;
    logic [N-1:0]   e_rdy = '0, e_rsv = '0;
    bit             m_busy = 0, m_acc = 0;
    int             m_win = 0, m_last = N - 1, m_tc = 0;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic m_finish(input logic err, input logic [RW-1:0] rd);
        m_busy = 0;
        e_psel = 0;
        e_pen  = 0;
        e_rsv  = '0;
        e_rsv[m_win] = 1'b1;
        e_err   = err;
        e_rdata = rd;
    endtask

    always @(posedge apb_pclk or negedge nreset) begin
        int j;
        if (!nreset) begin
            {e_psel, e_pen, e_pwrite, e_err} = '0;
            e_paddr = '0; e_pwdata = '0; e_rdata = '0;
            e_rdy = '0; e_rsv = '0;
            m_busy = 0; m_acc = 0; m_last = N - 1;
        end else begin
            e_rdy = '0; e_rsv = '0; e_rdata = '0; e_err = 0;
            if (!m_busy) begin
                j = rr_pick(m_last, req_valid);
                if (j >= 0) begin
                    m_busy = 1; m_acc = 0; m_win = j; m_last = j;
                    e_psel = 1; e_pen = 0;
                    e_pwrite = req_write[j];
                    e_paddr  = req_addr[j*RAW +: RAW];
                    e_pwdata = req_wdata[j*RW +: RW];
                    e_rdy[j] = 1'b1;
                end
            end else if (!m_acc) begin
                m_acc = 1; m_tc = 0; e_pen = 1;
            end else if (apb_pready) begin
                m_finish(apb_pslverr, e_pwrite ? '0 : apb_prdata);
            end else begin
                m_tc++;
`ifdef APBARB_TIMEOUT_EN
                if (m_tc == TOUT) m_finish(1'b1, '0);
`endif
            end
        end
    end

    always @(negedge apb_pclk) begin
        chk("psel", apb_psel, e_psel);
        chk("penable", apb_penable, e_pen);
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rsv);
        chk("pstrb", apb_pstrb, 4'hF);
        chk("pprot", apb_pprot, 3'b000);
        if (e_psel) begin
            chk("pwrite", apb_pwrite, e_pwrite);
            chk("paddr", apb_paddr, e_paddr);
            chk("pwdata", apb_pwdata, e_pwdata);
        end
        if (|e_rsv) begin
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_err", rsp_err, e_err);
        end
    end

    task automatic step();
        @(posedge apb_pclk);
        #2;
    endtask

    task automatic smp();
        @(negedge apb_pclk);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        req_valid = '0;
        repeat (2) step();
        nreset = 1'b1;
    endtask

    task automatic set_req(input int i, input logic w,
                           input logic [RAW-1:0] a, input logic [RW-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*RAW +: RAW] = a;
        req_wdata[i*RW +: RW]  = d;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 40 && idx < 0; c++) begin
            smp();
            for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        end
        if (idx < 0) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    always @(posedge apb_pclk) apb_prdata <= $urandom;

    initial begin
        int g;
        int exp2[5] = '{0, 1, 2, 3, 0};
        int exp5[3] = '{0, 2, 0};

        // Reset state
        step();
        #1;
        chk("rst_psel", apb_psel, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rsp", rsp_valid, 4'b0000);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_pstrb", apb_pstrb, 4'hF);
        do_reset();

        // Single write from requester 1
        apb_pready = 1;
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        req_valid = '0;
        smp();
        chk("t1_ready", req_ready, 4'b0010);
        chk("t1_psel", apb_psel, 1'b1);
        chk("t1_pen_c1", apb_penable, 1'b0);
        step(); smp();
        chk("t1_pen_c2", apb_penable, 1'b1);
        chk("t1_paddr", apb_paddr, 5'd5);
        chk("t1_pwdata", apb_pwdata, 32'hDEADBEEF);
        step(); smp();
        chk("t1_rsp", rsp_valid, 4'b0010);
        chk("t1_rdata", rsp_rdata, 32'd0);
        step();

        // All four reading, held
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'(i + 3), 32'(i));
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("t2_grant", 64'(g), 64'(exp2[k]));
        end
        step();
        req_valid = '0;
        repeat (4) step();

        // Wait states in ACCESS
        do_reset();
        apb_pready = 0;
        set_req(0, 1'b1, 5'd9, 32'hA5A5_0F0F);
        step();
        req_valid = '0;
        smp();
        chk("t3_ready", req_ready, 4'b0001);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) apb_pready = 1;
            smp();
            chk("t3_pen", apb_penable, 1'b1);
            chk("t3_paddr", apb_paddr, 5'd9);
            chk("t3_pwdata", apb_pwdata, 32'hA5A5_0F0F);
            chk("t3_norsp", rsp_valid, 4'b0000);
            step();
        end
        smp();
        chk("t3_rsp", rsp_valid, 4'b0001);
        step();

        // Reset during ACCESS
        do_reset();
        apb_pready = 0;
        set_req(2, 1'b0, 5'd1, 32'd0);
        step();
        req_valid = '0;
        step();
        nreset = 0;
        #1;
        chk("t4_psel", apb_psel, 1'b0);
        chk("t4_pen", apb_penable, 1'b0);
        apb_pready = 1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("t4_norsp", rsp_valid, 4'b0000);
        end
        step();
        set_req(0, 1'b0, 5'd2, 32'd0);
        set_req(3, 1'b0, 5'd3, 32'd0);
        nreset = 1;
        wait_grant(g);
        chk("t4_grant", 64'(g), 64'd0);
        step();
        req_valid = '0;
        repeat (4) step();

        // Late request from 0 interleaves with continuous 2
        do_reset();
        apb_pready = 1;
        set_req(2, 1'b0, 5'd7, 32'd0);
        wait_grant(g);
        chk("t5_first", 64'(g), 64'd2);
        step();
        set_req(0, 1'b0, 5'd4, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_grant(g);
            chk("t5_grant", 64'(g), 64'(exp5[k]));
        end
        step();
        req_valid = '0;
        repeat (4) step();

        // Completer never ready
        do_reset();
        apb_pready = 0;
        apb_pslverr = 0;
        set_req(1, 1'b0, 5'd6, 32'd0);
        step();
        req_valid = '0;
        step();
`ifdef APBARB_TIMEOUT_EN
        for (int k = 0; k < TOUT; k++) begin
            smp();
            chk("t6_wait", rsp_valid, 4'b0000);
            step();
        end
        smp();
        chk("t6_rsp", rsp_valid, 4'b0010);
        chk("t6_err", rsp_err, 1'b1);
        chk("t6_rdata", rsp_rdata, 32'd0);
        chk("t6_psel", apb_psel, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            smp();
            chk("t6_hold_psel", apb_psel, 1'b1);
            chk("t6_hold_pen", apb_penable, 1'b1);
            chk("t6_norsp", rsp_valid, 4'b0000);
            step();
        end
`endif
        apb_pready = 1;
        repeat (3) step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            step();
            apb_pready  = ($urandom % 3) != 0;
            apb_pslverr = ($urandom % 5) == 0;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) req_valid[i] = 1'b0;
                if ((req_ready[i] || !req_valid[i]) && ($urandom % 3) == 0)
                    set_req(i, 1'($urandom), 5'($urandom), 32'($urandom));
            end
        end
        req_valid = '0;
        apb_pready = 1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
